regalu_sequencer: RTL
=====================

Name: regalu_sequencer

Overview:
Single-clock controller that sequences the register-file/ALU datapath (read-register, ALU-execute, write-back phases) from a queued micro-op command stream. It replaces hand-driven phase strobes with one-cycle phase enables and holds addresses and opcode stable across each operation. It captures the ALU result and flags and reports completion. It sits between an instruction source (bench or a future decoder) and the register-file/ALU top.

Parameters:
ADDR_W, 5, register address width
OP_W, 4, ALU opcode width
DATA_W, 32, ALU result width
FLAG_W, 4, ALU flag width
CNT_W, 16, completed-operation counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready at rising edge
cmd_addr_a  in  ADDR_W  source A register
cmd_addr_b  in  ADDR_W  source B register
cmd_waddr  in  ADDR_W  destination register
cmd_alu_op  in  OP_W  ALU operation
cmd_wen  in  1  write result back
R_Addr_A  out  ADDR_W  to datapath
R_Addr_B  out  ADDR_W  to datapath
W_Addr  out  ADDR_W  to datapath
ALU_OP  out  OP_W  to datapath
Reg_Write  out  1  register-file write enable
rr_en  out  1  operand-latch enable (read phase)
ex_en  out  1  ALU result/flag latch enable
wb_en  out  1  write-back enable
alu_f  in  DATA_W  datapath result F
alu_fr  in  FLAG_W  datapath flags FR
done  out  1  one-cycle completion pulse
res_f  out  DATA_W  captured result
res_fr  out  FLAG_W  captured flags
busy  out  1  state != IDLE or pending valid
op_count  out  CNT_W  completed operations, wraps

Behaviour:
- Reset (async, any state): state=IDLE; pending register empty; all outputs 0. An in-flight op is dropped with no wb_en/Reg_Write pulse.
- One-entry pending register.
  - cmd_ready = !pend_v || state in {IDLE, WB}: the entry is consumed this cycle.
  - A simultaneous accept and consume replaces the entry.
- FSM IDLE->RR->EX->WB.
  - IDLE: if pend_v, latch pending fields into the output address/op registers, clear pend_v, go to RR.
  - RR: rr_en=1. Next state EX.
  - EX: ex_en=1. Next state WB.
  - WB: wb_en=1; Reg_Write=latched wen. res_f/res_fr <= alu_f/alu_fr at the end of this cycle. Then go to RR (loading the pending entry) if pend_v, else IDLE.
- Strobes rr_en, ex_en, wb_en and Reg_Write are registered, mutually exclusive and high for exactly one cycle per op.
- Latency: accept edge E0 -> RR cycle after E1 -> done high for the cycle after E4.
- Throughput: back-to-back ops issue every 3 cycles with no IDLE gap.
- done pulses the cycle after WB, in the same cycle res_* update. op_count increments at that edge; all-ones wraps to 0.
- R_Addr_A/R_Addr_B/W_Addr/ALU_OP are stable from the RR cycle through the WB cycle and hold their last value while IDLE.
- cmd_* are sampled only on accept; changes while not accepted are ignored.

Optional Feature:
REGALU_SEQ_SKIP_X0_EN
- Defined: an op with waddr==0 suppresses Reg_Write and wb_en in its WB cycle. Timing, result capture, done and op_count are unchanged.
- Undefined: write-back to address 0 is issued as commanded.

Decomposition:
- Package regalu_seq_pkg:
  - state enum {IDLE, RR, EX, WB}
  - packed cmd_t struct {addr_a, addr_b, waddr, alu_op, wen}
  - default width constants
- Optional sub-module regalu_cmd_slot: the one-entry pending register with its valid/ready logic. FSM and output registers stay in the top.

Test Plan:
- Reset, then a single cmd {a=0, b=1, w=2, op=0, wen=1} -> rr_en/ex_en/wb_en on consecutive cycles 1,2,3 after accept; Reg_Write only in the WB cycle with W_Addr=2; done the cycle after WB; op_count=1.
- With alu_f driven to 0x0000_0005 and alu_fr to 4'b0010 during WB -> res_f=0x5, res_fr=4'b0010 when done=1.
- cmd_valid held high with 3 cmds (w=2, 3, 4) -> ops issue every 3 cycles with no IDLE between; cmd_ready low once pending is full mid-op; done count=3.
- cmd {w=3, wen=0} -> wb_en high, Reg_Write stays 0, done still pulses.
- rst asserted during the EX cycle -> all outputs 0 immediately; no wb_en; op_count=0; next cmd runs normally.
- With REGALU_SEQ_SKIP_X0_EN, cmd {w=0, wen=1} -> wb_en=0 and Reg_Write=0; done and op_count still advance. Without the macro, wb_en=1 and Reg_Write=1.

Source files
------------

// File: rtl/regalu_seq_pkg.sv
// regalu_seq_pkg: shared types and default widths for the register-file/ALU
// sequencer.
//   state_e : sequencer phase (idle, read-register, execute, write-back)
//   cmd_t   : one micro-op command at the default widths
package regalu_seq_pkg;

   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned OP_W_DEF   = 4;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned FLAG_W_DEF = 4;
   localparam int unsigned CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      StIdle,
      StRr,
      StEx,
      StWb
   } state_e;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr_a;
      logic [ADDR_W_DEF-1:0] addr_b;
      logic [ADDR_W_DEF-1:0] waddr;
      logic [OP_W_DEF-1:0]   alu_op;
      logic                  wen;
   } cmd_t;

endpackage

// File: rtl/regalu_cmd_slot.sv
// regalu_cmd_slot: one-entry pending command register.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   valid_i, data_i  : offered command (packed fields)
//   ready_o          : command accepted on valid_i & ready_o at the rising edge
//   take_i           : consumer is able to take the entry this cycle
//   pend_v_o, pend_o : held entry
// A take and an accept in the same cycle replace the entry.
module regalu_cmd_slot #(
   parameter int unsigned Width = 20
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [Width-1:0] data_i,
   input  logic             take_i,
   output logic             ready_o,
   output logic             pend_v_o,
   output logic [Width-1:0] pend_o
);

   logic             pend_v_d, pend_v_q;
   logic [Width-1:0] pend_d, pend_q;

   assign ready_o  = !pend_v_q || take_i;
   assign pend_v_o = pend_v_q;
   assign pend_o   = pend_q;

   always_comb begin
      pend_v_d = pend_v_q;
      pend_d   = pend_q;
      if (valid_i && ready_o) begin
         pend_v_d = 1'b1;
         pend_d   = data_i;
      end else if (take_i) begin
         pend_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_v_q <= 1'b0;
         pend_q   <= '0;
      end else begin
         pend_v_q <= pend_v_d;
         pend_q   <= pend_d;
      end
   end

endmodule

// File: rtl/regalu_sequencer.sv
// regalu_sequencer: sequences read-register, execute and write-back phases of
// the register-file/ALU datapath from a queued micro-op stream.
//   clk, rst                 : clock, asynchronous active-high reset
//   cmd_*                    : command stream (valid/ready handshake)
//   R_Addr_A/B, W_Addr, ALU_OP : held datapath addresses/opcode
//   Reg_Write, rr_en, ex_en, wb_en : one-cycle registered phase strobes
//   alu_f, alu_fr            : datapath result/flags, captured at end of WB
//   done, res_f, res_fr      : completion pulse and captured result
//   busy, op_count           : activity indication, wrapping op counter
// Build option: REGALU_SEQ_SKIP_X0_EN suppresses wb_en/Reg_Write for waddr 0.
module regalu_sequencer
   import regalu_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned OP_W   = OP_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned FLAG_W = FLAG_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr_a,
   input  logic [ADDR_W-1:0] cmd_addr_b,
   input  logic [ADDR_W-1:0] cmd_waddr,
   input  logic [OP_W-1:0]   cmd_alu_op,
   input  logic              cmd_wen,
   output logic [ADDR_W-1:0] R_Addr_A,
   output logic [ADDR_W-1:0] R_Addr_B,
   output logic [ADDR_W-1:0] W_Addr,
   output logic [OP_W-1:0]   ALU_OP,
   output logic              Reg_Write,
   output logic              rr_en,
   output logic              ex_en,
   output logic              wb_en,
   input  logic [DATA_W-1:0] alu_f,
   input  logic [FLAG_W-1:0] alu_fr,
   output logic              done,
   output logic [DATA_W-1:0] res_f,
   output logic [FLAG_W-1:0] res_fr,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   localparam int unsigned CmdW = 3 * ADDR_W + OP_W + 1;

   state_e            state_q;
   logic              wen_q;
   logic              take;
   logic              pend_v;
   logic [CmdW-1:0]   pend;
   logic [ADDR_W-1:0] p_addr_a, p_addr_b, p_waddr;
   logic [OP_W-1:0]   p_alu_op;
   logic              p_wen;
   logic              wb_skip;

   // The slot may be drained while idle or in the last phase of an op.
   assign take = (state_q == StIdle) || (state_q == StWb);
   assign busy = (state_q != StIdle) || pend_v;

   regalu_cmd_slot #(
      .Width (CmdW)
   ) u_slot (
      .clk_i    (clk),
      .rst_i    (rst),
      .valid_i  (cmd_valid),
      .data_i   ({cmd_addr_a, cmd_addr_b, cmd_waddr, cmd_alu_op, cmd_wen}),
      .take_i   (take),
      .ready_o  (cmd_ready),
      .pend_v_o (pend_v),
      .pend_o   (pend)
   );

   assign p_addr_a = pend[CmdW-1 -: ADDR_W];
   assign p_addr_b = pend[CmdW-1-ADDR_W -: ADDR_W];
   assign p_waddr  = pend[OP_W+1 +: ADDR_W];
   assign p_alu_op = pend[1 +: OP_W];
   assign p_wen    = pend[0];

`ifdef REGALU_SEQ_SKIP_X0_EN
   assign wb_skip = (W_Addr == '0);
`else
   assign wb_skip = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         R_Addr_A  <= '0;
         R_Addr_B  <= '0;
         W_Addr    <= '0;
         ALU_OP    <= '0;
         wen_q     <= 1'b0;
         rr_en     <= 1'b0;
         ex_en     <= 1'b0;
         wb_en     <= 1'b0;
         Reg_Write <= 1'b0;
         done      <= 1'b0;
         res_f     <= '0;
         res_fr    <= '0;
         op_count  <= '0;
      end else begin
         rr_en     <= 1'b0;
         ex_en     <= 1'b0;
         wb_en     <= 1'b0;
         Reg_Write <= 1'b0;
         done      <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pend_v) begin
                  R_Addr_A <= p_addr_a;
                  R_Addr_B <= p_addr_b;
                  W_Addr   <= p_waddr;
                  ALU_OP   <= p_alu_op;
                  wen_q    <= p_wen;
                  rr_en    <= 1'b1;
                  state_q  <= StRr;
               end
            end
            StRr: begin
               ex_en   <= 1'b1;
               state_q <= StEx;
            end
            StEx: begin
               // Strobes are registered, so the WB-cycle values are set here.
               wb_en     <= !wb_skip;
               Reg_Write <= wen_q && !wb_skip;
               state_q   <= StWb;
            end
            StWb: begin
               res_f    <= alu_f;
               res_fr   <= alu_fr;
               done     <= 1'b1;
               op_count <= op_count + 1'b1;
               if (pend_v) begin
                  R_Addr_A <= p_addr_a;
                  R_Addr_B <= p_addr_b;
                  W_Addr   <= p_waddr;
                  ALU_OP   <= p_alu_op;
                  wen_q    <= p_wen;
                  rr_en    <= 1'b1;
                  state_q  <= StRr;
               end else begin
                  state_q <= StIdle;
               end
            end
         endcase
      end
   end

endmodule
